ras_checkpointed: RTL

Parametrised return address stack (RAS) for the branch prediction unit. It stores low-order return-target bits in a circular buffer and supports push on call, pop on return, and a combined push+pop. It exports a per-prediction checkpoint (pointer, count, top value) so that the pre-mispredict state can be restored exactly on a flush. It succeeds the fixed 8-entry RAS: depth and target width are generalised, and overflow wrap plus checkpoint repair are new behaviour.

---
 rtl/ras_checkpointed.sv | 111 +++++++++++
 1 files changed

// File: rtl/ras_checkpointed.sv
// Checkpointed return address stack: circular buffer of return targets
// with push/pop/push+pop and exact state repair from a saved checkpoint.
module ras_checkpointed #(
  parameter int RAS_DEPTH = 8,
  parameter int RAS_TARGET_WIDTH = 12,
  localparam int PTR_W = $clog2(RAS_DEPTH),
  localparam int CNT_W = $clog2(RAS_DEPTH + 1)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic                        top_valid,
  output logic [RAS_TARGET_WIDTH-1:0] top_target,
  output logic [PTR_W-1:0]            ckpt_ptr,
  output logic [CNT_W-1:0]            ckpt_count,
  output logic [RAS_TARGET_WIDTH-1:0] ckpt_top_target,
  input  logic                        restore_valid,
  input  logic [PTR_W-1:0]            restore_ptr,
  input  logic [CNT_W-1:0]            restore_count,
  input  logic [RAS_TARGET_WIDTH-1:0] restore_top_target
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             empty;
  logic             full;

  logic                        wr_en;
  logic [PTR_W-1:0]            wr_idx;
  logic [RAS_TARGET_WIDTH-1:0] wr_data;

  logic do_restore;
  logic do_swap;
  logic do_push;
  logic do_pop;

  assign ptr_inc = ptr_q + PTR_W'(1);
  assign ptr_dec = ptr_q - PTR_W'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);

  // One-hot operation select; push+pop on an empty stack folds into push.
  assign do_restore = restore_valid;
  assign do_swap    = !restore_valid && push_valid && pop_valid && !empty;
  assign do_push    = !restore_valid && push_valid && !do_swap;
  assign do_pop     = !restore_valid && !push_valid && pop_valid && !empty;

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = push_target;
    unique case (1'b1)
      do_restore: begin
        ptr_d   = restore_ptr;
        cnt_d   = restore_count;
        wr_en   = 1'b1;
        wr_idx  = restore_ptr;
        wr_data = restore_top_target;
      end
      do_swap: begin
        wr_en = 1'b1;
      end
      do_push: begin
        ptr_d  = ptr_inc;
        cnt_d  = full ? cnt_q : cnt_q + CNT_W'(1);
        wr_en  = 1'b1;
        wr_idx = ptr_inc;
      end
      do_pop: begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) begin
        stack_q[wr_idx] <= wr_data;
      end
    end
  end

  assign top_valid       = !empty;
  assign top_target      = stack_q[ptr_q];
  assign ckpt_ptr        = ptr_q;
  assign ckpt_count      = cnt_q;
  assign ckpt_top_target = stack_q[ptr_q];

endmodule
